// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu execute-stage block.
//   CMD_W_DEFAULT : default width of the command field
//   cmd_e         : command encodings 1..12 (CMD_NONE covers 0 and all unknown codes)
//   state_e       : handshake FSM states
//   is_iterative  : true for the multi-cycle multiply/divide commands
package alu_pkg;

  localparam int unsigned CMD_W_DEFAULT = 8;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_ADD   = 4'd1,
    CMD_SUB   = 4'd2,
    CMD_AND   = 4'd3,
    CMD_OR    = 4'd4,
    CMD_XOR   = 4'd5,
    CMD_SRL   = 4'd6,
    CMD_SRA   = 4'd7,
    CMD_SLL   = 4'd8,
    CMD_MUL   = 4'd9,
    CMD_MULHU = 4'd10,
    CMD_DIVU  = 4'd11,
    CMD_REMU  = 4'd12
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic is_iterative(input cmd_e c);
    return c inside {CMD_MUL, CMD_MULHU, CMD_DIVU, CMD_REMU};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : load operands and begin (ignored mid-operation by the caller)
//   is_div       : 1 = divide a / b, 0 = multiply a * b
//   a, b         : operands, sampled on start
//   done         : one-cycle pulse on the cycle of the final iteration
//   result       : valid with done; multiply -> full 2*WIDTH product,
//                  divide -> {remainder, quotient}
module mul_div_unit
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic               active;
  logic               div_q;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor
  logic [2*WIDTH-1:0] acc;      // {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;

  assign hi = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    sum = {1'b0, hi} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift next dividend bit into the remainder, subtract if it fits.
    shifted = {hi, acc[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_q) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  // The last iteration's value is handed out combinationally so the caller
  // can register it on the same edge, giving exactly WIDTH busy cycles.
  assign done   = active && (count == CNT_W'(WIDTH - 1));
  assign result = acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      div_q  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      div_q  <= is_div;
      opnd   <= is_div ? b : a;
      acc    <= (2*WIDTH)'(is_div ? a : b);
      count  <= '0;
    end else if (active) begin
      acc <= acc_next;
      if (done) begin
        active <= 1'b0;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked execute-stage ALU: eight single-cycle integer ops plus
// iterative unsigned mul/mulhu/divu/remu.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   io_in_valid/in_ready  : operation handshake (ready only when idle)
//   io_command            : operation code (unknown codes produce 0)
//   io_a, io_b            : operands
//   io_out_valid/out_ready: result handshake
//   io_out                : registered result, held until consumed
//   io_zero               : io_out == 0
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CMD_W = CMD_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [CMD_W-1:0] io_command,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e             state, state_next;
  cmd_e               op, op_q;
  logic               known;
  logic               iterative;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   result, result_next;
  logic [WIDTH-1:0]   md_sel;
  logic               md_start;
  logic               md_done;
  logic [2*WIDTH-1:0] md_res;

  // Decode: anything outside 1..12 collapses to CMD_NONE.
  always_comb begin
    known     = (io_command != '0) && (io_command <= CMD_W'(CMD_REMU));
    op        = known ? cmd_e'(io_command[3:0]) : CMD_NONE;
    iterative = is_iterative(op);
    sh        = io_b[SHW-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (op)
      CMD_ADD: alu_res = io_a + io_b;
      CMD_SUB: alu_res = io_a - io_b;
      CMD_AND: alu_res = io_a & io_b;
      CMD_OR:  alu_res = io_a | io_b;
      CMD_XOR: alu_res = io_a ^ io_b;
      CMD_SRL: alu_res = io_a >> sh;
      CMD_SRA: alu_res = $signed(io_a) >>> sh;
      CMD_SLL: alu_res = io_a << sh;
      default: alu_res = '0;
    endcase
  end

  mul_div_unit #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .is_div (op inside {CMD_DIVU, CMD_REMU}),
    .a      (io_a),
    .b      (io_b),
    .done   (md_done),
    .result (md_res)
  );

  always_comb begin
    case (op_q)
      CMD_MUL:  md_sel = md_res[WIDTH-1:0];
      CMD_MULHU: md_sel = md_res[2*WIDTH-1:WIDTH];
      CMD_DIVU: md_sel = md_res[WIDTH-1:0];
      default:  md_sel = md_res[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_next  = state;
    result_next = result;
    md_start    = 1'b0;
    case (state)
      S_IDLE: begin
        if (io_in_valid) begin
          if (iterative) begin
            md_start   = 1'b1;
            state_next = S_BUSY;
          end else begin
            result_next = alu_res;
            state_next  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          result_next = md_sel;
          state_next  = S_DONE;
        end
      end
      S_DONE: begin
        if (io_out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      op_q   <= CMD_NONE;
    end else begin
      state  <= state_next;
      result <= result_next;
      if (md_start) begin
        op_q <= op;
      end
    end
  end

  assign io_in_ready  = (state == S_IDLE);
  assign io_out_valid = (state == S_DONE);
  assign io_out       = result;
  assign io_zero      = (result == '0);

endmodule
